// File: rtl/paddle_pkg.sv
// Shared types and width helpers for the paddle locator.
// The CENTROID_EN build uses loc_state_t DIVIDE and the seq_divider sub-module.
package paddle_pkg;

  // Box fields are stored wide enough for any practical raster, then narrowed at the ports.
  localparam int BOX_W = 16;

  typedef struct packed {
    logic [BOX_W-1:0] x_min;
    logic [BOX_W-1:0] x_max;
    logic [BOX_W-1:0] y_min;
    logic [BOX_W-1:0] y_max;
  } box_t;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    DIVIDE  = 2'd1,
    PUBLISH = 2'd2
  } loc_state_t;

  // Empty box: min at all-ones and max at zero, so the first hit sets all four edges.
  localparam box_t BOX_INIT = '{x_min: '1, x_max: '0, y_min: '1, y_max: '0};

  function automatic int calc_x_w(input int line_width);
    return $clog2(line_width);
  endfunction

  function automatic int calc_y_w(input int frame_height);
    return $clog2(frame_height);
  endfunction

  function automatic int calc_cnt_w(input int line_width, input int frame_height);
    return $clog2(line_width * frame_height + 1);
  endfunction

endpackage

// File: rtl/paddle_locator_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle over the low STEPS dividend bits.
// The upper dividend bits are preloaded as the remainder, so the quotient must fit in STEPS bits.
module seq_divider #(
  parameter int DW    = 16,
  parameter int VW    = 8,
  parameter int STEPS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DW-1:0]    dividend,
  input  logic [VW-1:0]    divisor,
  output logic             busy,
  output logic             done,
  output logic [STEPS-1:0] quotient
);

  localparam int SW = $clog2(STEPS + 1);

  logic [VW-1:0]    rem_reg;
  logic [VW-1:0]    rem_next;
  logic [VW-1:0]    divisor_reg;
  logic [STEPS-1:0] quo_reg;
  logic [STEPS:0]   quo_shift;
  logic [SW-1:0]    step_reg;
  logic [VW:0]      trial;
  logic             take;

  // quo_reg shifts the unconsumed dividend bits out at the top and quotient bits in at the bottom.
  always_comb begin
    trial     = {rem_reg, quo_reg[STEPS-1]};
    take      = (trial >= {1'b0, divisor_reg});
    rem_next  = take ? VW'(trial - {1'b0, divisor_reg}) : VW'(trial);
    quo_shift = {quo_reg, take};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_reg     <= '0;
      divisor_reg <= '0;
      quo_reg     <= '0;
      step_reg    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_reg     <= VW'(dividend >> STEPS);
        quo_reg     <= dividend[STEPS-1:0];
        divisor_reg <= divisor;
        step_reg    <= SW'(STEPS);
        busy        <= 1'b1;
      end else if (busy) begin
        rem_reg  <= rem_next;
        quo_reg  <= quo_shift[STEPS-1:0];
        step_reg <= step_reg - SW'(1);
        if (step_reg == SW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo_reg;

endmodule

// File: rtl/paddle_locator.sv
// Tracks raster position, accumulates ROI edge hits and publishes one box per frame.
// Define CENTROID_EN to add hit centroid (sequential divide) and the overrun flag.
module paddle_locator
  import paddle_pkg::*;
#(
  parameter int LINE_WIDTH   = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int PIXEL_DEPTH  = 8,
  parameter int ROI_Y_MIN    = 400,
  parameter int ROI_Y_MAX    = 479,
  parameter int MIN_HITS     = 32,
  localparam int X_W   = calc_x_w(LINE_WIDTH),
  localparam int Y_W   = calc_y_w(FRAME_HEIGHT),
  localparam int CNT_W = calc_cnt_w(LINE_WIDTH, FRAME_HEIGHT)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_i,
  input  logic                   sof_i,
  input  logic [PIXEL_DEPTH-1:0] input_R,
  input  logic [PIXEL_DEPTH-1:0] input_G,
  input  logic [PIXEL_DEPTH-1:0] input_B,
  output logic                   box_valid_o,
  output logic                   found_o,
  output logic [X_W-1:0]         x_min_o,
  output logic [X_W-1:0]         x_max_o,
  output logic [Y_W-1:0]         y_min_o,
  output logic [Y_W-1:0]         y_max_o,
  output logic [CNT_W-1:0]       hit_count_o,
  output logic [X_W-1:0]         centroid_x_o,
  output logic [Y_W-1:0]         centroid_y_o,
  output logic                   overrun_o
);

  logic [X_W-1:0]   x_reg, x_cur;
  logic [Y_W-1:0]   y_reg, y_cur;
  box_t             box_reg, box_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             is_edge, hit, frame_end;
  loc_state_t       state_reg;
  logic             publish_now;
  box_t             pub_box;
  logic [CNT_W-1:0] pub_cnt;
  logic             pub_found;

  // sof_i relabels the current pixel as (0,0) and restarts accumulation from empty.
  always_comb begin
    x_cur     = sof_i ? '0 : x_reg;
    y_cur     = sof_i ? '0 : y_reg;
    is_edge   = (&input_R) | (&input_G) | (&input_B);
    hit       = valid_i && is_edge && (int'(y_cur) >= ROI_Y_MIN) && (int'(y_cur) <= ROI_Y_MAX);
    frame_end = valid_i && (int'(x_cur) == LINE_WIDTH - 1) && (int'(y_cur) == FRAME_HEIGHT - 1);
    box_next  = sof_i ? BOX_INIT : box_reg;
    cnt_next  = sof_i ? '0 : cnt_reg;
    if (hit) begin
      if (BOX_W'(x_cur) < box_next.x_min) box_next.x_min = BOX_W'(x_cur);
      if (BOX_W'(x_cur) > box_next.x_max) box_next.x_max = BOX_W'(x_cur);
      if (BOX_W'(y_cur) < box_next.y_min) box_next.y_min = BOX_W'(y_cur);
      if (BOX_W'(y_cur) > box_next.y_max) box_next.y_max = BOX_W'(y_cur);
      if (cnt_next != '1) cnt_next = cnt_next + CNT_W'(1);
    end
  end

  // The frame_end pixel is folded into the snapshot, so clearing here leaves no bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_reg   <= '0;
      y_reg   <= '0;
      box_reg <= BOX_INIT;
      cnt_reg <= '0;
    end else if (valid_i) begin
      if (int'(x_cur) == LINE_WIDTH - 1) begin
        x_reg <= '0;
        y_reg <= (int'(y_cur) == FRAME_HEIGHT - 1) ? '0 : y_cur + Y_W'(1);
      end else begin
        x_reg <= x_cur + X_W'(1);
        y_reg <= y_cur;
      end
      if (frame_end) begin
        box_reg <= BOX_INIT;
        cnt_reg <= '0;
      end else begin
        box_reg <= box_next;
        cnt_reg <= cnt_next;
      end
    end
  end

`ifdef CENTROID_EN
  localparam int XS_W = X_W + CNT_W;
  localparam int YS_W = Y_W + CNT_W;

  logic [XS_W-1:0]  x_sum_reg, x_sum_next;
  logic [YS_W-1:0]  y_sum_reg, y_sum_next;
  box_t             snap_box_reg;
  logic [CNT_W-1:0] snap_cnt_reg;
  logic             div_start, div_x_busy, div_y_busy, div_x_done, div_y_done;
  logic [CNT_W-1:0] quo_x, quo_y;
  logic [X_W-1:0]   centroid_x_reg;
  logic [Y_W-1:0]   centroid_y_reg;
  logic             overrun_reg;

  always_comb begin
    x_sum_next = sof_i ? '0 : x_sum_reg;
    y_sum_next = sof_i ? '0 : y_sum_reg;
    if (hit) begin
      x_sum_next = x_sum_next + XS_W'(x_cur);
      y_sum_next = y_sum_next + YS_W'(y_cur);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_sum_reg <= '0;
      y_sum_reg <= '0;
    end else if (valid_i) begin
      x_sum_reg <= frame_end ? '0 : x_sum_next;
      y_sum_reg <= frame_end ? '0 : y_sum_next;
    end
  end

  // A frame that ends while the divider is still working is dropped, not queued.
  assign div_start = frame_end && (state_reg != DIVIDE) && !div_x_busy && !div_y_busy;

  seq_divider #(.DW(XS_W), .VW(CNT_W), .STEPS(CNT_W)) u_div_x (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (x_sum_next),
    .divisor  (cnt_next),
    .busy     (div_x_busy),
    .done     (div_x_done),
    .quotient (quo_x)
  );

  seq_divider #(.DW(YS_W), .VW(CNT_W), .STEPS(CNT_W)) u_div_y (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (y_sum_next),
    .divisor  (cnt_next),
    .busy     (div_y_busy),
    .done     (div_y_done),
    .quotient (quo_y)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_box_reg   <= BOX_INIT;
      snap_cnt_reg   <= '0;
      centroid_x_reg <= '0;
      centroid_y_reg <= '0;
      overrun_reg    <= 1'b0;
    end else begin
      if (div_start) begin
        snap_box_reg <= box_next;
        snap_cnt_reg <= cnt_next;
      end else if (frame_end) begin
        overrun_reg <= 1'b1;
      end
      if (publish_now) begin
        centroid_x_reg <= (snap_cnt_reg == '0) ? '0 : X_W'(quo_x);
        centroid_y_reg <= (snap_cnt_reg == '0) ? '0 : Y_W'(quo_y);
      end
    end
  end

  assign publish_now  = (state_reg == DIVIDE) && div_x_done && div_y_done;
  assign pub_box      = snap_box_reg;
  assign pub_cnt      = snap_cnt_reg;
  assign centroid_x_o = centroid_x_reg;
  assign centroid_y_o = centroid_y_reg;
  assign overrun_o    = overrun_reg;
`else
  assign publish_now  = frame_end;
  assign pub_box      = box_next;
  assign pub_cnt      = cnt_next;
  assign centroid_x_o = '0;
  assign centroid_y_o = '0;
  assign overrun_o    = 1'b0;
`endif

  assign pub_found = (int'(pub_cnt) >= MIN_HITS);

  // Box edges only move for a found frame that actually had hits; the count always updates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ACCUM;
      box_valid_o <= 1'b0;
      found_o     <= 1'b0;
      x_min_o     <= '0;
      x_max_o     <= '0;
      y_min_o     <= '0;
      y_max_o     <= '0;
      hit_count_o <= '0;
    end else begin
      box_valid_o <= 1'b0;
      case (state_reg)
        DIVIDE: state_reg <= publish_now ? PUBLISH : DIVIDE;
        default: begin
`ifdef CENTROID_EN
          state_reg <= div_start ? DIVIDE : ACCUM;
`else
          state_reg <= frame_end ? PUBLISH : ACCUM;
`endif
        end
      endcase
      if (publish_now) begin
        box_valid_o <= 1'b1;
        found_o     <= pub_found;
        hit_count_o <= pub_cnt;
        if (pub_found && (pub_cnt != '0)) begin
          x_min_o <= X_W'(pub_box.x_min);
          x_max_o <= X_W'(pub_box.x_max);
          y_min_o <= Y_W'(pub_box.y_min);
          y_max_o <= Y_W'(pub_box.y_max);
        end
      end
    end
  end

endmodule

// File: tb/tb_paddle_locator.sv
// Scoreboard bench for paddle_locator on a 16x8 raster, ROI lines 4..7, MIN_HITS=4.
// With CENTROID_EN defined it also checks centroids, divide latency and overrun.
`timescale 1ns/1ps
module tb_paddle_locator;

  localparam int LW = 16, FH = 8, NPIX = LW * FH;
  localparam int X_W = 4, Y_W = 3, CNT_W = 8;
`ifdef CENTROID_EN
  localparam int LAT = CNT_W + 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset;
  logic valid_i, sof_i;
  logic [7:0] input_R, input_G, input_B;
  logic box_valid_o, found_o, overrun_o;
  logic [X_W-1:0] x_min_o, x_max_o, centroid_x_o;
  logic [Y_W-1:0] y_min_o, y_max_o, centroid_y_o;
  logic [CNT_W-1:0] hit_count_o;

  always #5 clk = ~clk;

  paddle_locator #(
    .LINE_WIDTH(LW), .FRAME_HEIGHT(FH), .PIXEL_DEPTH(8),
    .ROI_Y_MIN(4), .ROI_Y_MAX(7), .MIN_HITS(4)
  ) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .sof_i(sof_i),
    .input_R(input_R), .input_G(input_G), .input_B(input_B),
    .box_valid_o(box_valid_o), .found_o(found_o),
    .x_min_o(x_min_o), .x_max_o(x_max_o), .y_min_o(y_min_o), .y_max_o(y_max_o),
    .hit_count_o(hit_count_o), .centroid_x_o(centroid_x_o), .centroid_y_o(centroid_y_o),
    .overrun_o(overrun_o)
  );

`ifdef CENTROID_EN
  // 2x2 raster: frames end every 4 pixels, faster than the divide completes.
  logic t_valid;
  logic [7:0] t_pix;
  logic t_box_valid, t_found, t_overrun;
  logic [0:0] t_x_min, t_x_max, t_y_min, t_y_max, t_cx, t_cy;
  logic [2:0] t_cnt;
  paddle_locator #(
    .LINE_WIDTH(2), .FRAME_HEIGHT(2), .PIXEL_DEPTH(8),
    .ROI_Y_MIN(0), .ROI_Y_MAX(1), .MIN_HITS(1)
  ) dut_tiny (
    .clk(clk), .reset(reset), .valid_i(t_valid), .sof_i(1'b0),
    .input_R(t_pix), .input_G(8'h00), .input_B(8'h00),
    .box_valid_o(t_box_valid), .found_o(t_found),
    .x_min_o(t_x_min), .x_max_o(t_x_max), .y_min_o(t_y_min), .y_max_o(t_y_max),
    .hit_count_o(t_cnt), .centroid_x_o(t_cx), .centroid_y_o(t_cy),
    .overrun_o(t_overrun)
  );
`endif

  typedef struct packed {
    int cyc; int found; int cnt; int x0; int x1; int y0; int y1; int cx; int cy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0;
  int   frame_no = 0;
  int   chan_sel = 0;
  bit   hit_map[NPIX];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic exp_t mk_exp(input int found, input int cnt, input int x0, input int x1,
                                  input int y0, input int y1, input int cx, input int cy);
    exp_t e;
    e.cyc = 0; e.found = found; e.cnt = cnt;
    e.x0 = x0; e.x1 = x1; e.y0 = y0; e.y1 = y1;
`ifdef CENTROID_EN
    e.cx = cx; e.cy = cy;
`else
    e.cx = 0 * cx; e.cy = 0 * cy;
`endif
    return e;
  endfunction

  // Monitor: every strobe must match the oldest outstanding expectation, including its cycle.
  always @(negedge clk) begin
    if (!reset && box_valid_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_strobe: box_valid_o=1 at cycle %0d, required no strobe", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        frame_no++;
        $display("frame %0d @%0d: found=%0d cnt=%0d x %0d..%0d y %0d..%0d centroid (%0d,%0d)",
                 frame_no, cyc, found_o, hit_count_o, x_min_o, x_max_o, y_min_o, y_max_o,
                 centroid_x_o, centroid_y_o);
        check("strobe_cycle", cyc, mon_e.cyc);
        check("found", int'(found_o), mon_e.found);
        check("hit_count", int'(hit_count_o), mon_e.cnt);
        check("x_min", int'(x_min_o), mon_e.x0);
        check("x_max", int'(x_max_o), mon_e.x1);
        check("y_min", int'(y_min_o), mon_e.y0);
        check("y_max", int'(y_max_o), mon_e.y1);
        check("centroid_x", int'(centroid_x_o), mon_e.cx);
        check("centroid_y", int'(centroid_y_o), mon_e.cy);
      end
    end
  end

  task automatic drive_pixel(input logic sof, input logic edge_px);
    @(posedge clk); #1;
    valid_i = 1'b1; sof_i = sof;
    input_R = 8'h00; input_G = 8'h00; input_B = 8'h00;
    if (edge_px) begin
      case (chan_sel)
        0: input_R = 8'hFF;
        1: input_G = 8'hFF;
        default: input_B = 8'hFF;
      endcase
      chan_sel = (chan_sel + 1) % 3;
    end else begin
      input_G = 8'hFE;
    end
  endtask

  // Idle cycles present edge-looking data that must be ignored because valid_i is low.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      valid_i = 1'b0; sof_i = 1'b1;
      input_R = 8'hFF; input_G = 8'hFF; input_B = 8'hFF;
    end
  endtask

  task automatic clear_map();
    for (int i = 0; i < NPIX; i++) hit_map[i] = 1'b0;
  endtask

  task automatic run_frame(input int n_pix, input logic first_sof, input logic gaps, input exp_t e);
    exp_t ee;
    ee = e;
    for (int p = 0; p < n_pix; p++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) idle($urandom_range(1, 3));
      drive_pixel(first_sof && (p == 0), hit_map[p]);
      if (p == NPIX - 1) begin
        ee.cyc = cyc + LAT;
        exp_q.push_back(ee);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    valid_i = 1'b0; sof_i = 1'b0;
    input_R = 8'h00; input_G = 8'h00; input_B = 8'h00;
`ifdef CENTROID_EN
    t_valid = 1'b0; t_pix = 8'h00;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_box_valid", int'(box_valid_o), 0);
    check("reset_found", int'(found_o), 0);
    check("reset_hit_count", int'(hit_count_o), 0);
    check("reset_x_min", int'(x_min_o), 0);
    check("reset_y_max", int'(y_max_o), 0);
    check("reset_overrun", int'(overrun_o), 0);
    reset = 1'b0;

    // 1: four corner hits
    clear_map();
    hit_map[83] = 1; hit_map[89] = 1; hit_map[99] = 1; hit_map[105] = 1;
    run_frame(NPIX, 1'b0, 1'b0, mk_exp(1, 4, 3, 9, 5, 6, 6, 5));
    idle(LAT + 3);

    // 2: extra edges above the ROI change nothing
    hit_map[33] = 1; hit_map[44] = 1;
    run_frame(NPIX, 1'b0, 1'b0, mk_exp(1, 4, 3, 9, 5, 6, 6, 5));
    idle(LAT + 3);

    // 3: three hits incl. ROI boundary lines and the frame's last pixel -> not found
    clear_map();
    hit_map[64] = 1; hit_map[87] = 1; hit_map[127] = 1;
    run_frame(NPIX, 1'b0, 1'b0, mk_exp(0, 3, 3, 9, 5, 6, 7, 5));
    idle(LAT + 3);

    // 4: partial frame with ROI hits, then sof restarts; only the new frame counts
    clear_map();
    hit_map[65] = 1; hit_map[70] = 1; hit_map[90] = 1;
    run_frame(100, 1'b0, 1'b0, mk_exp(0, 0, 0, 0, 0, 0, 0, 0));
    clear_map();
    hit_map[117] = 1; hit_map[118] = 1; hit_map[121] = 1; hit_map[122] = 1;
    run_frame(NPIX, 1'b1, 1'b0, mk_exp(1, 4, 5, 10, 7, 7, 7, 7));
    idle(LAT + 3);

    // 5: test-1 hits with random valid gaps
    clear_map();
    hit_map[83] = 1; hit_map[89] = 1; hit_map[99] = 1; hit_map[105] = 1;
    run_frame(NPIX, 1'b0, 1'b1, mk_exp(1, 4, 3, 9, 5, 6, 6, 5));
    idle(LAT + 3);

    // 6: three hits on the last line -> centroid (5,7), box holds
    clear_map();
    hit_map[114] = 1; hit_map[116] = 1; hit_map[121] = 1;
    run_frame(NPIX, 1'b0, 1'b0, mk_exp(0, 3, 3, 9, 5, 6, 5, 7));
    idle(LAT + 3);

    // 7: empty frame
    clear_map();
    run_frame(NPIX, 1'b0, 1'b0, mk_exp(0, 0, 3, 9, 5, 6, 0, 0));
    idle(LAT + 3);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    idle(5);
    @(negedge clk);
    check("hold_box_valid", int'(box_valid_o), 0);
    check("hold_x_min", int'(x_min_o), 3);
    check("hold_y_max", int'(y_max_o), 6);
    check("hold_hit_count", int'(hit_count_o), 0);

`ifdef CENTROID_EN
    check("tiny_overrun_before", int'(t_overrun), 0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      t_valid = 1'b1; t_pix = 8'hFF;
    end
    @(posedge clk); #1;
    t_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("tiny_overrun_after", int'(t_overrun), 1);
`else
    check("overrun_tied", int'(overrun_o), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
